grostl_round_ctrl: RTL

Sequences the Grostl-256 compression function and output transformation over a shared single-round datapath. The datapath (AddRoundConstant, SubBytes, ShiftBytes, MixBytes) processes one P or Q round per cycle, and its P/Q select is driven by this block. Per cycle the controller issues the load, round-enable, round-index, P/Q select and finalisation strobes, and provides a scope trigger for power-trace acquisition.

---
 rtl/grostl_round_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/grostl_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : grostl_round_ctrl
// Brief    : Round sequencer for a shared Grostl-256 P/Q single-round datapath.
//            Optional stall input enabled by defining GROSTL_CTRL_STALL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module grostl_round_ctrl #(
    parameter int ROUNDS = 10,
    parameter int RW     = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          mode,
`ifdef GROSTL_CTRL_STALL_EN
    input  logic          stall,
`endif
    output logic          ready,
    output logic          ld,
    output logic [RW-1:0] rnd,
    output logic          pq,
    output logic          en_p,
    output logic          en_q,
    output logic          fin,
    output logic          done,
    output logic          trig
);

    typedef enum logic [1:0] {
        c_idle  = 2'd0,
        c_load  = 2'd1,
        c_run   = 2'd2,
        c_final = 2'd3
    } state_t;

    localparam logic [RW-1:0] c_last = RW'(ROUNDS - 1);

    state_t        r_state;
    logic          r_mode;
    logic [RW-1:0] r_rnd;
    logic          r_pq;
    logic          r_ready;
    logic          r_ld;
    logic          r_en_p;
    logic          r_en_q;
    logic          r_fin;
    logic          r_trig;

    logic          w_stall;
    logic          w_exit;

`ifdef GROSTL_CTRL_STALL_EN
    assign w_stall = stall & (r_state == c_run);
`else
    assign w_stall = 1'b0;
`endif

    // Mode 0 leaves RUN after the Q half of the last round, mode 1 after its only P round.
    assign w_exit = (r_rnd == c_last) && (r_mode || r_pq);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_idle;
            r_mode  <= 1'b0;
            r_rnd   <= '0;
            r_pq    <= 1'b0;
            r_ready <= 1'b1;
            r_ld    <= 1'b0;
            r_en_p  <= 1'b0;
            r_en_q  <= 1'b0;
            r_fin   <= 1'b0;
            r_trig  <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (start) begin
                        r_state <= c_load;
                        r_mode  <= mode;
                        r_ready <= 1'b0;
                        r_ld    <= 1'b1;
                    end
                end
                c_load: begin
                    r_state <= c_run;
                    r_ld    <= 1'b0;
                    r_rnd   <= '0;
                    r_pq    <= 1'b0;
                    r_en_p  <= 1'b1;
                    r_en_q  <= 1'b0;
                    r_trig  <= 1'b1;
                end
                c_run: begin
                    if (!w_stall) begin
                        r_trig <= 1'b0;
                        if (w_exit) begin
                            r_state <= c_final;
                            r_en_p  <= 1'b0;
                            r_en_q  <= 1'b0;
                            r_fin   <= 1'b1;
                        end else if (!r_mode && !r_pq) begin
                            r_pq   <= 1'b1;
                            r_en_p <= 1'b0;
                            r_en_q <= 1'b1;
                        end else begin
                            r_rnd  <= r_rnd + 1'b1;
                            r_pq   <= 1'b0;
                            r_en_p <= 1'b1;
                            r_en_q <= 1'b0;
                        end
                    end
                end
                c_final: begin
                    r_state <= c_idle;
                    r_fin   <= 1'b0;
                    r_ready <= 1'b1;
                    r_rnd   <= '0;
                    r_pq    <= 1'b0;
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    // A stalled RUN cycle must not clock either state register or fire the scope trigger.
    assign ready = r_ready;
    assign ld    = r_ld;
    assign rnd   = r_rnd;
    assign pq    = r_pq;
    assign en_p  = r_en_p & ~w_stall;
    assign en_q  = r_en_q & ~w_stall;
    assign fin   = r_fin;
    assign done  = r_fin;
    assign trig  = r_trig & ~w_stall;

endmodule
`default_nettype wire
